// File: rtl/sprite_scheduler_pkg.sv
// Shared constants and types for the per-scanline sprite scheduler.
// Screen/sprite geometry lives here so the table and engines agree on sizes.
package sprite_scheduler_pkg;

    localparam int unsigned RES_V         = 480;
    localparam int unsigned SPRITE_HEIGHT = 8;
    localparam int unsigned SPRITE_SCALE  = 2;
    localparam int unsigned SPR_LINES     = SPRITE_HEIGHT * SPRITE_SCALE;

    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = $clog2(RES_V);
    localparam int unsigned BUSY_W = $clog2(SPR_LINES + 1);

    typedef logic [BUSY_W-1:0] busy_t;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } sched_state_e;

endpackage

// File: rtl/sprite_scheduler_engine_alloc.sv
// Lowest-index free engine picker: a combinational priority encoder over busy flags.
module sprite_scheduler_engine_alloc #(
    parameter int unsigned NUM_ENGINES = 2,
    parameter int unsigned IDX_W       = 1
) (
    input  logic [NUM_ENGINES-1:0] busy,
    output logic                   free_found,
    output logic [IDX_W-1:0]       free_idx
);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        // Walk downwards so the lowest free index is the one left standing.
        for (int e = int'(NUM_ENGINES) - 1; e >= 0; e--) begin
            if (!busy[e]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(e);
            end
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Scans the sprite slot table once per horizontal blank and hands matching slots to free
// draw engines; tracks engine occupancy in lines and merges the engines' pixel outputs.
module sprite_scheduler
    import sprite_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 8,
    parameter int unsigned NUM_ENGINES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           line_start,
    input  logic                           frame_start,
    input  logic [Y_W-1:0]                 pixel_y,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SLOTS)-1:0]   wr_idx,
    input  logic [X_W-1:0]                 wr_x,
    input  logic [Y_W-1:0]                 wr_y,
    input  logic                           wr_valid,
    input  logic [NUM_ENGINES-1:0]         eng_draw,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*X_W-1:0]     eng_x,
    output logic                           eng_clear,
    output logic                           pixel_draw,
    output logic [$clog2(NUM_SLOTS)-1:0]   hit_slot,
    output logic                           scan_busy,
    output logic                           overflow
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned ENG_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    logic [X_W-1:0]       slot_x_q [NUM_SLOTS];
    logic [Y_W-1:0]       slot_y_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid_q;

    sched_state_e               state_q, state_d;
    logic [SLOT_W-1:0]          scan_idx_q, scan_idx_d;
    logic [Y_W-1:0]             line_y_q, line_y_d;
    busy_t                      busy_q [NUM_ENGINES];
    busy_t                      busy_d [NUM_ENGINES];
    logic [SLOT_W-1:0]          tag_q [NUM_ENGINES];
    logic [SLOT_W-1:0]          tag_d [NUM_ENGINES];
    logic [NUM_ENGINES*X_W-1:0] eng_x_q, eng_x_d;
    logic [NUM_ENGINES-1:0]     eng_start_q, eng_start_d;
    logic                       eng_clear_q, eng_clear_d;
    logic                       overflow_q, overflow_d;

    logic [NUM_ENGINES-1:0] busy_flag;
    logic                   free_found;
    logic [ENG_W-1:0]       free_idx;
    logic                   slot_match;

    always_comb begin
        for (int e = 0; e < int'(NUM_ENGINES); e++) begin
            busy_flag[e] = (busy_q[e] != '0);
        end
    end

    sprite_scheduler_engine_alloc #(
        .NUM_ENGINES (NUM_ENGINES),
        .IDX_W       (ENG_W)
    ) u_engine_alloc (
        .busy       (busy_flag),
        .free_found (free_found),
        .free_idx   (free_idx)
    );

    // Table reads are combinational from registers, so a same-cycle write is seen next pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
            end
            slot_valid_q <= '0;
        end else if (wr_en) begin
            slot_x_q[wr_idx]     <= wr_x;
            slot_y_q[wr_idx]     <= wr_y;
            slot_valid_q[wr_idx] <= wr_valid;
        end
    end

    assign slot_match = (state_q == StScan) && slot_valid_q[scan_idx_q]
                        && (slot_y_q[scan_idx_q] == line_y_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        line_y_d    = line_y_q;
        busy_d      = busy_q;
        tag_d       = tag_q;
        eng_x_d     = eng_x_q;
        eng_start_d = '0;
        eng_clear_d = 1'b0;
        overflow_d  = overflow_q;

        if (frame_start) begin
            state_d     = StIdle;
            eng_clear_d = 1'b1;
            overflow_d  = 1'b0;
            for (int e = 0; e < int'(NUM_ENGINES); e++) begin
                busy_d[e] = '0;
            end
        end else if (line_start) begin
            // A new line arriving mid-scan means the blank was too short for this table.
            if (state_q == StScan) begin
                overflow_d = 1'b1;
            end
            state_d    = StScan;
            scan_idx_d = '0;
            line_y_d   = pixel_y;
            for (int e = 0; e < int'(NUM_ENGINES); e++) begin
                busy_d[e] = (busy_q[e] != '0) ? busy_q[e] - busy_t'(1) : '0;
            end
        end else if (state_q == StScan) begin
            if (slot_match) begin
                if (free_found) begin
                    eng_start_d[free_idx]                = 1'b1;
                    eng_x_d[int'(free_idx)*X_W +: X_W]   = slot_x_q[scan_idx_q];
                    busy_d[free_idx]                     = busy_t'(SPR_LINES);
                    tag_d[free_idx]                      = scan_idx_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (scan_idx_q == SLOT_W'(NUM_SLOTS - 1)) begin
                state_d = StIdle;
            end
            scan_idx_d = scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_q  <= '0;
            line_y_q    <= '0;
            for (int e = 0; e < int'(NUM_ENGINES); e++) begin
                busy_q[e] <= '0;
                tag_q[e]  <= '0;
            end
            eng_x_q     <= '0;
            eng_start_q <= '0;
            eng_clear_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            scan_idx_q  <= scan_idx_d;
            line_y_q    <= line_y_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            eng_x_q     <= eng_x_d;
            eng_start_q <= eng_start_d;
            eng_clear_q <= eng_clear_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        scan_busy  = (state_q == StScan);
        eng_start  = eng_start_q;
        eng_x      = eng_x_q;
        eng_clear  = eng_clear_q;
        overflow   = overflow_q;
        pixel_draw = |eng_draw;
        hit_slot   = '0;
        for (int e = int'(NUM_ENGINES) - 1; e >= 0; e--) begin
            if (eng_draw[e]) begin
                hit_slot = tag_q[e];
            end
        end
    end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Per-scanline scheduler that shares a small pool of draw_sprite engines among a larger table of sprite slots (player, invaders, shots).
- Game logic writes slot positions into the table.
- In each horizontal blank the block scans the table and assigns every slot starting on the upcoming line to a free engine, driving that engine's start and x position.
- It tracks engine occupancy by line count, merges engine pixel outputs, and flags overflow when slots outnumber free engines.

Parameters:
- NUM_SLOTS, 8, number of sprite slots in the table (power of 2, ≥2).
- NUM_ENGINES, 2, number of draw_sprite instances driven (1..8).
- SPR_LINES, SPRITE_HEIGHT*SPRITE_SCALE, screen lines one sprite occupies (from shared constants).

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous reset, active-high
- line_start  in  1  one-cycle pulse at the start of horizontal blank
- frame_start  in  1  one-cycle pulse in vertical blank, before line 0's line_start
- pixel_y  in  $clog2(RES_V)  line about to be displayed; sampled on line_start
- wr_en  in  1  slot-table write strobe
- wr_idx  in  $clog2(NUM_SLOTS)  slot index to write
- wr_x  in  10  slot x position
- wr_y  in  $clog2(RES_V)  slot y position
- wr_valid  in  1  slot enable bit written
- eng_draw  in  NUM_ENGINES  spr_draw from each engine
- eng_start  out  NUM_ENGINES  one-cycle start pulse per engine
- eng_x  out  NUM_ENGINES*10  spr_x per engine, engine e at bits [10e+9:10e]
- eng_clear  out  1  one-cycle pulse; integration ORs it into every engine's rst
- pixel_draw  out  1  OR of eng_draw
- hit_slot  out  $clog2(NUM_SLOTS)  slot drawn by the lowest-index engine with eng_draw=1
- scan_busy  out  1  high while the scan is in progress
- overflow  out  1  sticky; a matching slot found no free engine this frame

Behaviour:
- Reset values:
  - all outputs 0; eng_x all 0.
  - slot table: valid=0, x=0, y=0.
  - per-engine busy counters 0; engine slot tags 0; state IDLE.
- Slot table:
  - synchronous write on wr_en, any state.
  - During SCAN, a write to the slot read in the same cycle is seen on the next frame/line: the read returns the old value.
- State machine: IDLE, SCAN, and implementation-local states only if zero-latency-equivalent.
  - IDLE -> SCAN on line_start:
    - latch pixel_y.
    - decrement every nonzero busy counter by 1 in that same edge.
    - scan index <= 0.
  - SCAN examines one slot per cycle, index i at cycle t+1+i (t = line_start edge).
    - Match when valid && y == latched pixel_y.
  - On a match with a free engine (busy==0, including engines freed by this line's decrement):
    - choose the lowest free engine index e.
    - next edge: eng_start[e]=1 for exactly one cycle, eng_x[e]<=slot x (held until the next assignment), busy[e]<=SPR_LINES, tag[e]<=i.
    - e counts as busy for later slots in the same scan.
  - On a match with no free engine: overflow<=1 and the slot is skipped for this frame.
  - SCAN -> IDLE after slot NUM_SLOTS-1; scan_busy=1 exactly during cycles t+1..t+NUM_SLOTS.
  - Lower slot index always wins an engine.
- Timing requirement: NUM_SLOTS+2 cycles must fit in horizontal blank. The block does not check this; the integration checks it against the VGA timing.
- line_start during SCAN:
  - abort the current scan and set overflow.
  - restart per the IDLE->SCAN rule, including the decrement.
- frame_start:
  - next edge: all busy counters<=0, eng_clear=1 for one cycle, overflow<=0, state<=IDLE (aborts any scan).
  - frame_start wins over a simultaneous line_start; that line_start is ignored.
  - Slot table is untouched.
- pixel_draw/hit_slot are combinational from eng_draw and the tags; hit_slot=0 when pixel_draw=0.
- busy counter width is $clog2(SPR_LINES+1); it never underflows and saturates at 0.
- Reset mid-scan: everything returns to reset values immediately (asynchronous).

Decomposition:
- The shared constants file (`include "../util/constants.v") supplies RES_H, RES_V, SPRITE_WIDTH, SPRITE_HEIGHT, SPRITE_SCALE and a new SPR_LINES constant.
- One sub-module, engine_alloc: a combinational lowest-free-engine priority encoder over the busy flags, outputs free_found and free_idx.
- Slot table and FSM stay in sprite_scheduler.

Test Plan:
- Basic assignment:
  - stimulus: reset; write slot 3 (x=100, y=50, valid); line_start with pixel_y=50.
  - response: eng_start[0] pulses at t+5; eng_x[0]=100; engine 0 stays busy for SPR_LINES lines; it is reassignable on line 50+SPR_LINES.
- Engine priority:
  - stimulus: slots 1 and 5 both at y=20 (x=10, 200); line_start with pixel_y=20.
  - response: engine 0 gets x=10 at t+3; engine 1 gets x=200 at t+7; overflow=0.
- Overflow:
  - stimulus: NUM_ENGINES=2, three valid slots (0, 2, 4) at y=30.
  - response: slot 4 gets no start; overflow=1 until frame_start, then 0.
- Line_start during scan:
  - stimulus: second line_start at t+3.
  - response: overflow=1; scan restarts from slot 0; no duplicate start for an already-assigned slot, because its engine is busy.
- Frame clear:
  - stimulus: frame_start coincident with line_start while both engines busy.
  - response: eng_clear pulse; busy counters 0; no scan starts; next line_start assigns engine 0.
- Pixel merge:
  - stimulus: eng_draw=2'b10, tag[1]=6.
  - response: pixel_draw=1, hit_slot=6; eng_draw=0 gives hit_slot=0.
